sub_div_combine_4_bit: RTL and testbench

Inverse-direction companion to the combined 4-bit adder/multiplier datapath. Computes the difference a-b (mod 2^WIDTH, with a borrow flag) and the unsigned quotient/remainder a/b. Division uses an iterative restoring divider that produces one quotient bit per clock, under a start/busy/done handshake. Sits beside the add/mul block so that software-side checks can undo its results.

---
 rtl/sub_div_combine_4_bit_pkg.sv | 17 +
 rtl/sub_div_combine_4_bit_if.sv | 31 +++
 rtl/sub_div_combine_4_bit_div_restore_step.sv | 27 ++
 rtl/sub_div_combine_4_bit.sv | 132 +++++++++++++
 tb/tb_sub_div_combine_4_bit.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sub_div_combine_4_bit_pkg.sv
// Shared types and constants for the subtract/divide companion block.
package sub_div_combine_4_bit_pkg;

    // Default operand/result width; the divider runs this many iterations.
    localparam int DEF_WIDTH = 4;

    // Quotient reported when the captured divisor is zero.
    localparam logic [DEF_WIDTH-1:0] DIV_BY_ZERO_QUOT = '1;

    // Control states of the iterative divider.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : sub_div_combine_4_bit_pkg

// File: rtl/sub_div_combine_4_bit_if.sv
// Request/result bundle between a requester (master) and the sub/div block (slave).
interface sub_div_combine_4_bit_if
    import sub_div_combine_4_bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result_sub;
    logic             Result_borrow;
    logic [WIDTH-1:0] Result_quot;
    logic [WIDTH-1:0] Result_rem;
    logic             div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, Result_sub, Result_borrow,
               Result_quot, Result_rem, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, Result_sub, Result_borrow,
               Result_quot, Result_rem, div_by_zero
    );

endinterface : sub_div_combine_4_bit_if

// File: rtl/sub_div_combine_4_bit_div_restore_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module sub_div_combine_4_bit_div_restore_step
    import sub_div_combine_4_bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // The trial value is one bit wider than the remainder; after a successful
    // subtract (or a failed compare) the result always fits back in WIDTH bits.
    always_comb begin
        trial = {rem_i, bit_i};
        diff  = trial - {1'b0, b_i};
        q_o   = (trial >= {1'b0, b_i});
        rem_o = WIDTH'(q_o ? diff : trial);
    end

endmodule : sub_div_combine_4_bit_div_restore_step

// File: rtl/sub_div_combine_4_bit.sv
// Wrapping subtract plus iterative restoring divider (one quotient bit per
// clock) behind a start/busy/done handshake.
module sub_div_combine_4_bit
    import sub_div_combine_4_bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sub_div_combine_4_bit_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Dividend shifts out at the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sub_q, sub_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    sub_div_combine_4_bit_div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (acc_q),
        .bit_i (dvd_q[WIDTH-1]),
        .b_i   (b_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Next-state and datapath update; everything holds unless a state acts on it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        dvd_d    = dvd_q;
        acc_d    = acc_q;
        sub_d    = sub_q;
        borrow_d = borrow_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    sub_d    = bus.a - bus.b;
                    borrow_d = (bus.a < bus.b);
                    acc_d    = '0;
                    dvd_d    = bus.a;
                    cnt_d    = CNT_W'(WIDTH - 1);
                    dbz_d    = (bus.b == '0);
                    state_d  = DIV;
                end
            end
            DIV: begin
                acc_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    // Divide-by-zero still runs the iterations for fixed timing,
                    // then overrides the results. Replicated so any width gets all ones.
                    quot_d  = dbz_q ? {WIDTH{DIV_BY_ZERO_QUOT[0]}}
                                    : {dvd_q[WIDTH-2:0], step_q};
                    rem_d   = dbz_q ? a_q : step_rem;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dvd_q    <= '0;
            acc_q    <= '0;
            sub_q    <= '0;
            borrow_q <= 1'b0;
            quot_q   <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dvd_q    <= dvd_d;
            acc_q    <= acc_d;
            sub_q    <= sub_d;
            borrow_q <= borrow_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = (state_q == DONE);
    assign bus.Result_sub    = sub_q;
    assign bus.Result_borrow = borrow_q;
    assign bus.Result_quot   = quot_q;
    assign bus.Result_rem    = rem_q;
    assign bus.div_by_zero   = dbz_q;

endmodule : sub_div_combine_4_bit

// File: tb/tb_sub_div_combine_4_bit.sv
// Directed and exhaustive checks of the subtract/divide block against a
// reference model held in a scoreboard queue.
module tb_sub_div_combine_4_bit;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    sub_div_combine_4_bit_if #(.WIDTH(W)) bus ();

    sub_div_combine_4_bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sub;
        logic         borrow;
        logic [W-1:0] quot;
        logic [W-1:0] rem;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a      = a;
        e.b      = b;
        e.sub    = W'((a + 5'd16 - b) % 16);
        e.borrow = (a < b);
        e.dbz    = (b == 0);
        e.quot   = (b == 0) ? 4'hF : W'(a / b);
        e.rem    = (b == 0) ? a : W'(a % b);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},   32'(bus.busy),          32'd0);
        chk({tag, "_done"},   32'(bus.done),          32'd0);
        chk({tag, "_sub"},    32'(bus.Result_sub),    32'd0);
        chk({tag, "_borrow"}, 32'(bus.Result_borrow), 32'd0);
        chk({tag, "_quot"},   32'(bus.Result_quot),   32'd0);
        chk({tag, "_rem"},    32'(bus.Result_rem),    32'd0);
        chk({tag, "_dbz"},    32'(bus.div_by_zero),   32'd0);
    endtask

    // Called at a negedge while the DUT is idle.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        sb.push_back(model(a, b));
    endtask

    // Called at the negedge following the accept edge.
    task automatic check_accept();
        exp_t e;
        if (sb.size() == 0) begin
            chk("accept_sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb[0];
            chk("accept_sub",    32'(bus.Result_sub),    32'(e.sub));
            chk("accept_borrow", 32'(bus.Result_borrow), 32'(e.borrow));
            chk("accept_busy",   32'(bus.busy),          32'd1);
            chk("accept_done",   32'(bus.done),          32'd0);
        end
    endtask

    // Counts negedges until done; busy must stay high throughout.
    task automatic wait_done();
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            chk("busy_held", 32'(bus.busy), 32'd1);
        end
        chk("done_latency", 32'(n), 32'd4);
    endtask

    // Called at the negedge where done is high; ends at the following negedge.
    task automatic check_done();
        exp_t e;
        if (sb.size() == 0) begin
            chk("done_sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("quot", 32'(bus.Result_quot), 32'(e.quot));
            chk("rem",  32'(bus.Result_rem),  32'(e.rem));
            chk("dbz",  32'(bus.div_by_zero), 32'(e.dbz));
            $display("txn a=%0d b=%0d sub=%0d borrow=%0d quot=%0d rem=%0d dbz=%0d",
                     e.a, e.b, bus.Result_sub, bus.Result_borrow,
                     bus.Result_quot, bus.Result_rem, bus.div_by_zero);
            @(negedge clk);
            chk("done_pulse", 32'(bus.done), 32'd0);
            chk("idle_busy",  32'(bus.busy), 32'd0);
            chk("hold_quot",  32'(bus.Result_quot), 32'(e.quot));
            chk("hold_rem",   32'(bus.Result_rem),  32'(e.rem));
        end
    endtask

    // Full transaction; operands are scrambled after capture.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
        drive_start(a, b);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        check_accept();
        wait_done();
        check_done();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        op(4'd13, 4'd3);
        op(4'd3, 4'd13);
        op(4'd9, 4'd0);

        // Start held through DIV/DONE with new operands
        drive_start(4'd15, 4'd1);
        @(negedge clk);
        bus.a = 4'd8;
        bus.b = 4'd2;
        sb.push_back(model(4'd8, 4'd2));
        check_accept();
        wait_done();
        chk("held_sub_kept", 32'(bus.Result_sub), 32'd14);
        check_done();
        chk("held_not_reaccepted", 32'(bus.Result_sub), 32'd14);
        @(negedge clk);
        bus.start = 1'b0;
        check_accept();
        wait_done();
        check_done();

        // Reset in the middle of a division
        drive_start(4'd14, 4'd4);
        @(negedge clk);
        bus.start = 1'b0;
        check_accept();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midreset_no_done", 32'(bus.done), 32'd0);
        end
        rst_n = 1'b1;
        op(4'd14, 4'd4);

        // Exhaustive back-to-back sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                op(W'(ia), W'(ib));
            end
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sub_div_combine_4_bit
